// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
// The optional starvation guard is selected with MEM_ARB_STARVE_GUARD_EN.
package mem_arb_pkg;

  localparam int unsigned XLEN               = 32;
  localparam int unsigned STARVE_MAX_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_e;

  // Width of a counter that must be able to hold the value max_count.
  function automatic int unsigned ctr_width(input int unsigned max_count);
    return (max_count < 2) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Counts consecutive data grants issued while a fetch is waiting and asks the
// arbiter to serve the fetch once the limit is reached.
module mem_arb_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic fetch_pending_i,
  input  logic data_grant_i,
  input  logic fetch_grant_i,
  output logic force_fetch_o
);

  localparam int unsigned CW = ctr_width(STARVE_MAX);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_MAX);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (!fetch_pending_i || fetch_grant_i) begin
      count_d = '0;
    end else if (data_grant_i && (count_q != LIMIT)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign force_fetch_o = fetch_pending_i && (count_q == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the instruction-fetch and load/store ports onto one memory port.
// Data has fixed priority; defining MEM_ARB_STARVE_GUARD_EN bounds fetch starvation.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic            if_valid,
  output logic [XLEN-1:0] if_data,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  output logic            d_valid,
  output logic [XLEN-1:0] d_rdata,
  output logic            m_req,
  output logic            m_we,
  output logic [XLEN-1:0] m_addr,
  output logic [XLEN-1:0] m_wdata,
  input  logic            m_ack,
  input  logic [XLEN-1:0] m_rdata,
  output logic            stall
);

  if (STARVE_MAX == 0) begin : g_starve_max_range
    $error("mem_arbiter: STARVE_MAX must be at least 1");
  end

  arb_state_e      state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic            we_q, we_d;
  logic            if_valid_q, if_valid_d;
  logic            d_valid_q, d_valid_d;
  logic [XLEN-1:0] if_data_q, if_data_d;
  logic [XLEN-1:0] d_rdata_q, d_rdata_d;

  logic grant_en;
  logic data_grant;
  logic fetch_grant;
  logic force_fetch;

  // A request line still high in its own completion cycle belongs to the
  // finished transaction, so nothing is granted until it has settled.
  assign grant_en = (state_q == IDLE)
                 && !(if_valid_q && if_req)
                 && !(d_valid_q && d_req);

  // NOTE: every signal driven here gets a default first, so no latch is inferred.
  always_comb begin
    data_grant  = 1'b0;
    fetch_grant = 1'b0;
    if (grant_en) begin
      if (if_req && force_fetch) begin
        fetch_grant = 1'b1;
      end else if (d_req) begin
        data_grant = 1'b1;
      end else if (if_req) begin
        fetch_grant = 1'b1;
      end
    end
  end

`ifdef MEM_ARB_STARVE_GUARD_EN
  mem_arb_starve_ctr #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve_ctr (
    .clk             (clk),
    .reset           (reset),
    .fetch_pending_i (if_req),
    .data_grant_i    (data_grant),
    .fetch_grant_i   (fetch_grant),
    .force_fetch_o   (force_fetch)
  );
`else
  assign force_fetch = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    if_valid_d = 1'b0;
    d_valid_d  = 1'b0;
    if_data_d  = if_data_q;
    d_rdata_d  = d_rdata_q;

    case (state_q)
      IDLE: begin
        if (data_grant) begin
          state_d = BUSY_D;
          addr_d  = d_addr;
          wdata_d = d_wdata;
          we_d    = d_we;
        end else if (fetch_grant) begin
          state_d = BUSY_I;
          addr_d  = if_addr;
          wdata_d = '0;
          we_d    = 1'b0;
        end
      end
      BUSY_I: begin
        if (m_ack) begin
          state_d    = IDLE;
          if_valid_d = 1'b1;
          if_data_d  = m_rdata;
        end
      end
      BUSY_D: begin
        if (m_ack) begin
          state_d   = IDLE;
          d_valid_d = 1'b1;
          // A store completes without touching the last load word.
          if (!we_q) begin
            d_rdata_d = m_rdata;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; reset is synchronous.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
      if_data_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      if_valid_q <= if_valid_d;
      d_valid_q  <= d_valid_d;
      if_data_q  <= if_data_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign m_req    = (state_q != IDLE);
  assign m_we     = (state_q == BUSY_D) && we_q;
  assign m_addr   = addr_q;
  assign m_wdata  = wdata_q;
  assign if_valid = if_valid_q;
  assign if_data  = if_data_q;
  assign d_valid  = d_valid_q;
  assign d_rdata  = d_rdata_q;
  assign stall    = (if_req && !if_valid_q) || (d_req && !d_valid_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected grants are queued with the stimulus,
// a memory model acks and queues expected completions, a monitor compares them.
module tb_mem_arbiter;

  localparam int ACK_LAT    = 2;
  localparam int STARVE_MAX = 4;
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  typedef struct packed {
    logic        is_fetch;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } grant_t;

  typedef struct packed {
    logic        is_fetch;
    logic [31:0] data;
  } cpl_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, if_valid, d_req, d_we, d_valid;
  logic [31:0] if_addr, if_data, d_addr, d_wdata, d_rdata;
  logic        m_req, m_we, m_ack, stall;
  logic [31:0] m_addr, m_wdata, m_rdata;

  int n_checks = 0;
  int n_errors = 0;
  int cyc_cnt  = 0;
  int ack_cyc, d_valid_cyc, i_start_cyc;

  grant_t      grant_q[$];
  cpl_t        cpl_q[$];
  logic [31:0] mem [logic [31:0]];
  logic [31:0] last_load;
  logic [31:0] saved;
  bit          auto_ack, force_ack;
  cpl_t        mon_e;

  mem_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk     (clk),
    .reset   (reset),
    .if_req  (if_req),
    .if_addr (if_addr),
    .if_valid(if_valid),
    .if_data (if_data),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_valid (d_valid),
    .d_rdata (d_rdata),
    .m_req   (m_req),
    .m_we    (m_we),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_ack   (m_ack),
    .m_rdata (m_rdata),
    .stall   (stall)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic push_grant(input bit f, input bit we, input logic [31:0] a, input logic [31:0] wd);
    grant_q.push_back('{is_fetch: f, we: we, addr: a, wdata: wd});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic issue_fetch(input logic [31:0] a);
    push_grant(1'b1, 1'b0, a, 32'h0);
    if_req  = 1'b1;
    if_addr = a;
  endtask

  task automatic issue_data(input bit we, input logic [31:0] a, input logic [31:0] wd);
    push_grant(1'b0, we, a, wd);
    d_req   = 1'b1;
    d_we    = we;
    d_addr  = a;
    d_wdata = wd;
  endtask

  // Called right after a request is raised: no m_req this cycle, m_req next cycle.
  task automatic check_grant_latency(input string tag);
    @(negedge clk);
    check({tag, "_pre"}, 32'(m_req), 32'd0);
    @(negedge clk);
    check({tag, "_grant"}, 32'(m_req), 32'd1);
  endtask

  // Waits for n completions; requesters drop their line on their valid pulse unless held.
  task automatic run_until(input string tag, input int n_done, input bit held, input int budget);
    int done = 0;
    int cyc  = 0;
    while (done < n_done && cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
      if (if_valid) begin
        done++;
        if (!held) if_req = 1'b0;
      end
      if (d_valid) begin
        done++;
        if (!held) d_req = 1'b0;
      end
      if (held && done >= n_done) begin
        if_req = 1'b0;
        d_req  = 1'b0;
      end
    end
    check(tag, 32'(done), 32'(n_done));
  endtask

  // Memory model: acks ACK_LAT cycles after the first m_req cycle.
  initial begin
    grant_t cur;
    int     age;
    cur   = '0;
    age   = 0;
    m_ack = 1'b0;
    m_rdata = 32'h0;
    forever begin
      @(posedge clk); #1;
      m_ack   = 1'b0;
      m_rdata = $urandom();
      age     = m_req ? age + 1 : 0;
      if (age == 1) begin
        check("grant_expected", 32'(grant_q.size() > 0), 32'd1);
        if (grant_q.size() > 0) cur = grant_q.pop_front();
        if (cur.is_fetch) i_start_cyc = cyc_cnt;
        if (cur.we) check("m_wdata", m_wdata, cur.wdata);
      end
      if (age >= 1) begin
        check("m_addr", m_addr, cur.addr);
        check("m_we", 32'(m_we), 32'(cur.we));
      end
      if (force_ack) begin
        m_ack = 1'b1;
      end else if (auto_ack && age == ACK_LAT + 1) begin
        m_ack   = 1'b1;
        ack_cyc = cyc_cnt;
        if (cur.we) begin
          mem[cur.addr] = cur.wdata;
          cpl_q.push_back('{is_fetch: 1'b0, data: last_load});
        end else begin
          m_rdata = mem_rd(cur.addr);
          if (!cur.is_fetch) last_load = m_rdata;
          cpl_q.push_back('{is_fetch: cur.is_fetch, data: m_rdata});
        end
      end
    end
  end

  // Completion monitor and per-cycle interface checks, away from the active edge.
  always @(negedge clk) begin
    check("stall", 32'(stall), 32'((if_req & ~if_valid) | (d_req & ~d_valid)));
    if (!m_req) check("m_we_idle", 32'(m_we), 32'd0);
    if (if_valid) begin
      check("if_valid_expected", 32'(cpl_q.size() > 0 && cpl_q[0].is_fetch), 32'd1);
      if (cpl_q.size() > 0) begin
        mon_e = cpl_q.pop_front();
        check("if_data", if_data, mon_e.data);
      end
      check("ack_to_if_valid", 32'(cyc_cnt - ack_cyc), 32'd1);
    end
    if (d_valid) begin
      d_valid_cyc = cyc_cnt;
      check("d_valid_expected", 32'(cpl_q.size() > 0 && !cpl_q[0].is_fetch), 32'd1);
      if (cpl_q.size() > 0) begin
        mon_e = cpl_q.pop_front();
        check("d_rdata", d_rdata, mon_e.data);
      end
      check("ack_to_d_valid", 32'(cyc_cnt - ack_cyc), 32'd1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; auto_ack = 1'b1; force_ack = 1'b0; last_load = '0;
    mem[32'h100] = 32'h2402000A;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_m_req", 32'(m_req), 32'd0);
    check("rst_m_we", 32'(m_we), 32'd0);
    check("rst_if_valid", 32'(if_valid), 32'd0);
    check("rst_d_valid", 32'(d_valid), 32'd0);
    check("rst_if_data", if_data, 32'h0);
    check("rst_d_rdata", d_rdata, 32'h0);
    check("rst_m_addr", m_addr, 32'h0);
    check("rst_m_wdata", m_wdata, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    idle(1);

    // Fetch-only.
    issue_fetch(32'h100);
    check_grant_latency("fetch_lat");
    run_until("fetch_done", 1, 1'b0, 50);
    check("fetch_word", if_data, 32'h2402000A);

    // Stray ack while idle.
    idle(1);
    @(negedge clk); force_ack = 1'b1;
    @(negedge clk); force_ack = 1'b0;
    check("stray_m_req", 32'(m_req), 32'd0);
    @(negedge clk);
    check("stray_no_if_valid", 32'(if_valid), 32'd0);
    check("stray_no_d_valid", 32'(d_valid), 32'd0);
    check("stray_m_req_after", 32'(m_req), 32'd0);
    check("stray_if_data", if_data, 32'h2402000A);
    @(posedge clk); #1;

    // Simultaneous fetch and load: data first, fetch after one idle bubble.
    issue_data(1'b0, 32'h200, 32'h0);
    issue_fetch(32'h104);
    run_until("conflict_done", 2, 1'b0, 100);
    check("conflict_bubble", 32'(i_start_cyc - d_valid_cyc), 32'd1);
    check("conflict_load", d_rdata, mem_rd(32'h200));

    // Store keeps d_rdata; load reads the stored word back.
    idle(1);
    saved = d_rdata;
    issue_data(1'b1, 32'h40, 32'hDEADBEEF);
    run_until("store_done", 1, 1'b0, 50);
    check("store_keeps_rdata", d_rdata, saved);
    idle(1);
    issue_data(1'b0, 32'h40, 32'h0);
    run_until("load_back_done", 1, 1'b0, 50);
    check("load_back", d_rdata, 32'hDEADBEEF);

    // Both requesters held high: strict data priority, or one fetch after STARVE_MAX data grants.
    idle(1);
    for (int k = 0; k < 6; k++) begin
      if (GUARD && k == STARVE_MAX) push_grant(1'b1, 1'b0, 32'h108, 32'h0);
      else                          push_grant(1'b0, 1'b0, 32'h300, 32'h0);
    end
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
    if_req = 1'b1; if_addr = 32'h108;
    run_until("held_done", 6, 1'b1, 400);
    idle(3);
    check("held_grants_drained", 32'(grant_q.size()), 32'd0);

    // Reset in the middle of a fetch, then a late ack.
    auto_ack = 1'b0;
    issue_fetch(32'h10C);
    for (int k = 0; k < 10 && !m_req; k++) begin
      @(posedge clk); #1;
    end
    check("rst_busy", 32'(m_req), 32'd1);
    reset  = 1'b1;
    if_req = 1'b0;
    @(negedge clk); force_ack = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk); force_ack = 1'b0;
    check("rst_abandon_m_req", 32'(m_req), 32'd0);
    @(negedge clk);
    check("rst_no_if_valid", 32'(if_valid), 32'd0);
    check("rst_idle", 32'(m_req), 32'd0);
    check("rst_abandon_if_data", if_data, 32'h0);
    check("rst_abandon_d_rdata", d_rdata, 32'h0);
    auto_ack = 1'b1;
    @(posedge clk); #1;

    // Arbiter is idle and serves a new fetch normally.
    idle(1);
    issue_fetch(32'h110);
    check_grant_latency("post_rst_lat");
    run_until("post_rst_done", 1, 1'b0, 50);

    idle(4);
    check("grants_drained", 32'(grant_q.size()), 32'd0);
    check("completions_drained", 32'(cpl_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
